bit_demux_deserializer: RTL
===========================

// Module: bit_demux_deserializer
// PURPOSE
//   Receive-side counterpart of the bit-select mux serializer: a sequential 1-to-WIDTH demux.
//   Steers each incoming serial bit into the word slot chosen by an internal index counter.
//   Presents each completed word on a valid/ready output with a one-word holding register.
//   Sits between serial operand sources and the parallel operand inputs of the Booth multiplier datapath.
// PARAMETERS
//   WIDTH      8   bits per assembled word (>=2)
//   MSB_FIRST  0   0: first bit lands in bit 0; 1: first bit lands in bit WIDTH-1
//   SEL_W      $clog2(WIDTH)   index width; derived, not overridden
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   clear      in   1        sync abort of the partial word in assembly
//   in_bit     in   1        serial data bit
//   in_valid   in   1        in_bit is valid this cycle
//   in_ready   out  1        block accepts in_bit this cycle
//   out_word   out  WIDTH    assembled word
//   out_valid  out  1        out_word holds an unconsumed word
//   out_ready  in   1        consumer takes out_word this cycle
//   bit_idx    out  SEL_W    number of bits already in the current partial word
// BEHAVIOUR
//   Reset (async, rst=1): idx=0, assembly reg=0, out_word=0, out_valid=0; all take effect immediately, mid-word included.
//   Accept: the block accepts a bit when in_valid & in_ready at a rising edge.
//   Slot: pos = MSB_FIRST ? WIDTH-1-idx : idx. On accept, asm[pos] <= in_bit and idx <= idx+1.
//   Last bit: idx==WIDTH-1 marks the last bit.
//   - On accepting the last bit, out_word <= asm with in_bit inserted at pos, in the same edge.
//   - In that same edge, out_valid <= 1, idx <= 0 and asm <= 0.
//   Latency: out_valid rises on the edge that accepts the last bit, so the word is visible in the next cycle.
//   in_ready = !clear & ((idx != WIDTH-1) | !out_valid | out_ready). It is combinational from out_ready.
//   - Bits 0..WIDTH-2 of a word are accepted even while a previous word is pending.
//   - Only the last bit stalls on a full holding register.
//   Output handshake:
//   - out_valid & out_ready with no new word in the same edge -> out_valid <= 0; out_word keeps its value.
//   - Consume and load in the same edge -> out_valid stays 1 and out_word takes the new word, with no bubble.
//   - out_word is stable while out_valid & !out_ready.
//   clear=1:
//   - idx <= 0 and asm <= 0.
//   - in_ready=0, so no bit is accepted in that cycle.
//   - The holding register (out_word, out_valid) is unaffected.
//   - clear has priority over any in_valid in the same cycle.
//   Throughput: with in_valid=1 and out_ready=1 held, one word every WIDTH cycles, with no idle cycles between words.
//   Wrap-around: after the last bit, idx returns to 0. idx never exceeds WIDTH-1.
//   in_bit is ignored when it is not accepted. There is no overrun: the block stalls instead.
// TESTING
//   1. WIDTH=8, MSB_FIRST=0, out_ready=1, stream 1,0,1,1,0,0,1,0 -> out_word=8'h4D and out_valid=1 for exactly 1 cycle, after the 8th accept edge.
//   2. MSB_FIRST=1, same stream -> out_word=8'hB2.
//   3. Backpressure: word 8'h4D pending with out_ready=0, then stream 8'hFF.
//      -> 7 bits accepted, bit_idx=7, in_ready=0, out_word holds 8'h4D.
//      -> Raise out_ready: 8'h4D consumed and the 8th bit accepted in the same edge; out_valid stays 1 and out_word=8'hFF.
//   4. Streaming: in_valid=1, out_ready=1 for 32 cycles with alternating bits -> 4 words of 8'h55, one every 8 cycles, in_ready=1 throughout.
//   5. Clear: 3 bits of 1 accepted (bit_idx=3), clear=1 for 1 cycle, then 8 zeros.
//      -> bit_idx=0 after clear, output word=8'h00, no stale 1s in the word.
//   6. Async reset: rst pulsed mid-word (bit_idx=5) and with out_valid=1.
//      -> out_valid=0, out_word=0, bit_idx=0 before the next clk edge; the next 8 bits form a clean word.

Source files
------------

// File: rtl/bit_demux_deserializer_if.sv
// Serial-in / word-out handshake bundle for the bit demux deserializer.
// master = bit source and word consumer side, slave = the deserializer.
interface bit_demux_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(WIDTH);

  logic             clear;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] bit_idx;

  modport master (
    output clear, in_bit, in_valid, out_ready,
    input  in_ready, out_word, out_valid, bit_idx
  );

  modport slave (
    input  clear, in_bit, in_valid, out_ready,
    output in_ready, out_word, out_valid, bit_idx
  );
endinterface

// File: rtl/bit_demux_deserializer.sv
// Sequential 1-to-WIDTH demux: serial bits are steered into word slots by an
// index counter; finished words sit in a one-deep valid/ready holding register.
module bit_demux_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input logic clk,
  input logic rst,
  bit_demux_deserializer_if.slave bus
);
  localparam int SEL_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;

  logic             last;
  logic             in_ready;
  logic             accept;
  logic [SEL_W-1:0] pos;
  logic [WIDTH-1:0] ins;

  always_comb begin
    last     = (idx_q == LAST);
    // Only the final bit of a word needs room in the holding register.
    in_ready = !bus.clear && (!last || !out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    pos      = (MSB_FIRST != 0) ? (LAST - idx_q) : idx_q;
    ins      = asm_q;
    ins[pos] = bus.in_bit;

    idx_d       = idx_q;
    asm_d       = asm_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (bus.clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (last) begin
        // A load in the same edge as a consume keeps out_valid high: no bubble.
        idx_d       = '0;
        asm_d       = '0;
        out_word_d  = ins;
        out_valid_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
        asm_d = ins;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      asm_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = out_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bit_idx   = idx_q;
endmodule
